// File: rtl/ula_pkg.sv
// ula_pkg: op codes, FSM states and flag bundle shared by the multi-cycle ULA.
`default_nettype none

package ula_pkg;

    localparam logic [3:0] ULA_ADD  = 4'b0000;
    localparam logic [3:0] ULA_SUB  = 4'b0001;
    localparam logic [3:0] ULA_AND  = 4'b0010;
    localparam logic [3:0] ULA_OR   = 4'b0011;
    localparam logic [3:0] ULA_XOR  = 4'b0100;
    localparam logic [3:0] ULA_SLT  = 4'b0101;
    localparam logic [3:0] ULA_SLL  = 4'b0110;
    localparam logic [3:0] ULA_SRL  = 4'b0111;
    localparam logic [3:0] ULA_SRA  = 4'b1000;
    localparam logic [3:0] ULA_MUL  = 4'b1001;
    localparam logic [3:0] ULA_DIVU = 4'b1010;
    localparam logic [3:0] ULA_REMU = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
        logic divzero;
    } flags_t;

endpackage

`default_nettype wire

// File: rtl/ula_iter_unit.sv
// ula_iter_unit: shared shift-add multiplier / restoring divider, one bit per step.
// Divider path is built only when ULA_DIV_EN is defined.
`default_nettype none

module ula_iter_unit #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             div_mode,
    input  logic             step,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             finished,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opb;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   base;
    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   sum;
    logic             cin;

`ifdef ULA_DIV_EN
    logic mode;
`else
    logic unused_div_mode;
    assign unused_div_mode = div_mode;
`endif

    // One adder serves both: hi+B (multiply) or {hi,lo msb}-B (divide).
    always_comb begin
        base   = {1'b0, hi};
        addend = lo[0] ? {1'b0, opb} : '0;
        cin    = 1'b0;
`ifdef ULA_DIV_EN
        if (mode) begin
            base   = {hi, lo[WIDTH-1]};
            addend = ~{1'b0, opb};
            cin    = 1'b1;
        end
`endif
        sum    = base + addend + {{WIDTH{1'b0}}, cin};
        res_hi = sum[WIDTH:1];
        res_lo = {sum[0], lo[WIDTH-1:1]};
`ifdef ULA_DIV_EN
        if (mode) begin
            if (sum[WIDTH]) begin
                res_hi = base[WIDTH-1:0];
                res_lo = {lo[WIDTH-2:0], 1'b0};
            end else begin
                res_hi = sum[WIDTH-1:0];
                res_lo = {lo[WIDTH-2:0], 1'b1};
            end
        end
`endif
    end

    assign finished = step && (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi    <= '0;
            lo    <= '0;
            opb   <= '0;
            count <= '0;
`ifdef ULA_DIV_EN
            mode  <= 1'b0;
`endif
        end else if (load) begin
            hi    <= '0;
            lo    <= op_a;
            opb   <= op_b;
            count <= '0;
`ifdef ULA_DIV_EN
            mode  <= div_mode;
`endif
        end else if (step) begin
            hi    <= res_hi;
            lo    <= res_lo;
            count <= count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ula_multiciclo.sv
// ula_multiciclo: registered ULA with Start/Busy/Done handshake and iterative MUL/DIVU/REMU.
// Define ULA_DIV_EN to build the divider; otherwise 1010/1011 act as reserved op codes.
`default_nettype none

module ula_multiciclo
    import ula_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [3:0]       ULAControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ULAResult,
    output logic [WIDTH-1:0] ULAResultHi,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow,
    output logic             DivZero
);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       op_q;
    flags_t           flags;
    logic             accept;
    logic             is_mul;
    logic             div_iter;
    logic             load;
    logic             finished;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] iter_res;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sc_res;
    logic             sc_carry;
    logic             sc_ovf;
    logic             sc_dz;

    assign accept = Start && (state == S_IDLE);
    assign is_mul = (ULAControl == ULA_MUL);
`ifdef ULA_DIV_EN
    assign div_iter = ((ULAControl == ULA_DIVU) || (ULAControl == ULA_REMU)) && (SrcB != '0);
`else
    assign div_iter = 1'b0;
`endif
    assign load   = accept && (is_mul || div_iter);
    assign Busy   = (state != S_IDLE);

    ula_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .div_mode (div_iter),
        .step     (Busy),
        .op_a     (SrcA),
        .op_b     (SrcB),
        .finished (finished),
        .res_hi   (res_hi),
        .res_lo   (res_lo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:       if (load) state_nxt = is_mul ? S_MUL : S_DIV;
            S_MUL, S_DIV: if (finished) state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    assign add_full = {1'b0, SrcA} + {1'b0, SrcB};
    assign sub_full = {1'b0, SrcA} + {1'b0, ~SrcB} + (WIDTH+1)'(1);
    assign shamt    = SrcB[SHW-1:0];

    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_dz    = 1'b0;
        case (ULAControl)
            ULA_ADD: begin
                sc_res   = add_full[WIDTH-1:0];
                sc_carry = add_full[WIDTH];
                sc_ovf   = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (sc_res[WIDTH-1] != SrcA[WIDTH-1]);
            end
            ULA_SUB: begin
                sc_res   = sub_full[WIDTH-1:0];
                sc_carry = sub_full[WIDTH];
                sc_ovf   = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (sc_res[WIDTH-1] != SrcA[WIDTH-1]);
            end
            ULA_AND: sc_res = SrcA & SrcB;
            ULA_OR:  sc_res = SrcA | SrcB;
            ULA_XOR: sc_res = SrcA ^ SrcB;
            ULA_SLT: sc_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
            ULA_SLL: sc_res = SrcA << shamt;
            ULA_SRL: sc_res = SrcA >> shamt;
            ULA_SRA: sc_res = $unsigned($signed(SrcA) >>> shamt);
`ifdef ULA_DIV_EN
            // Only reaches here as a single-cycle op when the divisor is zero.
            ULA_DIVU: begin
                sc_res = '1;
                sc_dz  = 1'b1;
            end
            ULA_REMU: begin
                sc_res = SrcA;
                sc_dz  = 1'b1;
            end
`endif
            default: sc_res = '0;
        endcase
    end

    always_comb begin
        iter_res = res_lo;
        iter_hi  = '0;
        if (op_q == ULA_MUL)       iter_hi  = res_hi;
        else if (op_q == ULA_REMU) iter_res = res_hi;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) op_q <= '0;
        else if (load) op_q <= ULAControl;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Done        <= 1'b0;
            ULAResult   <= '0;
            ULAResultHi <= '0;
            flags       <= '0;
        end else begin
            Done <= 1'b0;
            if (accept && !load) begin
                Done        <= 1'b1;
                ULAResult   <= sc_res;
                ULAResultHi <= '0;
                flags       <= '{zero: (sc_res == '0), negative: sc_res[WIDTH-1],
                                 carry: sc_carry, overflow: sc_ovf, divzero: sc_dz};
            end else if (finished) begin
                Done        <= 1'b1;
                ULAResult   <= iter_res;
                ULAResultHi <= iter_hi;
                flags       <= '{zero: (iter_res == '0), negative: iter_res[WIDTH-1],
                                 carry: 1'b0, overflow: 1'b0, divzero: 1'b0};
            end
        end
    end

    assign Zero     = flags.zero;
    assign Negative = flags.negative;
    assign Carry    = flags.carry;
    assign Overflow = flags.overflow;
    assign DivZero  = flags.divzero;

endmodule

`default_nettype wire

// File: tb/tb_ula_multiciclo.sv
// tb_ula_multiciclo: directed and randomized checks of ula_multiciclo against a behavioural model.
`default_nettype none

module tb_ula_multiciclo;

    localparam int WIDTH = 8;
    localparam int MASK  = (1 << WIDTH) - 1;
    localparam int HALF  = 1 << (WIDTH - 1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             Start = 1'b0;
    logic [3:0]       ULAControl = '0;
    logic [WIDTH-1:0] SrcA = '0;
    logic [WIDTH-1:0] SrcB = '0;
    logic             Busy, Done, Zero, Negative, Carry, Overflow, DivZero;
    logic [WIDTH-1:0] ULAResult, ULAResultHi;

    int n_cmp  = 0;
    int n_fail = 0;
    int cycle  = 0;

    always #5 clk = ~clk;

    ula_multiciclo #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .Start       (Start),
        .ULAControl  (ULAControl),
        .SrcA        (SrcA),
        .SrcB        (SrcB),
        .Busy        (Busy),
        .Done        (Done),
        .ULAResult   (ULAResult),
        .ULAResultHi (ULAResultHi),
        .Zero        (Zero),
        .Negative    (Negative),
        .Carry       (Carry),
        .Overflow    (Overflow),
        .DivZero     (DivZero)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] hi;
        logic        z, n, c, v, dz, iter;
    } expect_t;

    function automatic int to_signed(int x);
        return (x >= HALF) ? x - (1 << WIDTH) : x;
    endfunction

    // Reference behaviour from the op definitions, using plain integer arithmetic.
    function automatic expect_t model_op(int op, int a, int b);
        expect_t e;
        int sa, sb, sh, s, p;
        e  = '0;
        sa = to_signed(a);
        sb = to_signed(b);
        sh = b % WIDTH;
        case (op)
            0: begin
                s = sa + sb;
                e.res = (a + b) & MASK;
                e.c = (a + b) > MASK;
                e.v = (s >= HALF) || (s < -HALF);
            end
            1: begin
                s = sa - sb;
                e.res = (a - b) & MASK;
                e.c = (a >= b);
                e.v = (s >= HALF) || (s < -HALF);
            end
            2: e.res = a & b;
            3: e.res = a | b;
            4: e.res = a ^ b;
            5: e.res = (a < b) ? 1 : 0;
            6: e.res = (a << sh) & MASK;
            7: e.res = a >> sh;
            8: e.res = (sa >>> sh) & MASK;
            9: begin
                p = a * b;
                e.res = p & MASK;
                e.hi = p >> WIDTH;
                e.iter = 1'b1;
            end
`ifdef ULA_DIV_EN
            10: begin
                if (b == 0) begin e.res = MASK; e.dz = 1'b1; end
                else begin e.res = a / b; e.iter = 1'b1; end
            end
            11: begin
                if (b == 0) begin e.res = a; e.dz = 1'b1; end
                else begin e.res = a % b; e.iter = 1'b1; end
            end
`endif
            default: e.res = 0;
        endcase
        e.z = (e.res == 0);
        e.n = ((e.res >> (WIDTH - 1)) & 1) != 0;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs as seen at each rising edge
    logic       s_reset = 1'b1;
    logic       s_start = 1'b0;
    logic [3:0] s_op = '0;
    logic [WIDTH-1:0] s_a = '0, s_b = '0;

    always @(posedge clk) begin
        s_reset <= reset;
        s_start <= Start;
        s_op    <= ULAControl;
        s_a     <= SrcA;
        s_b     <= SrcB;
        cycle   <= cycle + 1;
    end

    expect_t m_out;
    expect_t m_pend;
    logic    m_done = 1'b0;
    int      m_busy = 0;

    initial begin
        expect_t e;
        m_out  = '0;
        m_pend = '0;
        forever begin
            @(negedge clk);
            if (reset || s_reset) begin
                m_out  = '0;
                m_done = 1'b0;
                m_busy = 0;
            end else begin
                m_done = 1'b0;
                if (m_busy > 0) begin
                    m_busy--;
                    if (m_busy == 0) begin
                        m_out  = m_pend;
                        m_done = 1'b1;
                    end
                end else if (s_start) begin
                    e = model_op(int'(s_op), int'(s_a), int'(s_b));
                    if (e.iter) begin
                        m_pend = e;
                        m_busy = WIDTH;
                    end else begin
                        m_out  = e;
                        m_done = 1'b1;
                    end
                end
            end
            n_cmp++;
            if (Done !== m_done || Busy !== (m_busy > 0) ||
                ULAResult !== WIDTH'(m_out.res) || ULAResultHi !== WIDTH'(m_out.hi) ||
                {Zero, Negative, Carry, Overflow, DivZero} !==
                {m_out.z, m_out.n, m_out.c, m_out.v, m_out.dz}) begin
                n_fail++;
                $display("FAIL model_cycle%0d: got done=%b busy=%b res=%h hi=%h zncvd=%b, expected done=%b busy=%b res=%h hi=%h zncvd=%b",
                         cycle, Done, Busy, ULAResult, ULAResultHi,
                         {Zero, Negative, Carry, Overflow, DivZero},
                         m_done, (m_busy > 0), WIDTH'(m_out.res), WIDTH'(m_out.hi),
                         {m_out.z, m_out.n, m_out.c, m_out.v, m_out.dz});
            end
        end
    end

    // Issue one op, wait (bounded) for Done and check literal expectations.
    task automatic run_op(input string name, input int op, input int a, input int b,
                          input int exp_res, input int exp_hi, input int exp_dz,
                          input int exp_busy);
        int  busy_cycles;
        bit  seen;
        @(posedge clk); #1;
        Start = 1'b1; ULAControl = 4'(op); SrcA = WIDTH'(a); SrcB = WIDTH'(b);
        @(posedge clk); #1;
        Start = 1'b0;
        busy_cycles = 0;
        seen = 1'b0;
        for (int i = 0; i < 4 * WIDTH; i++) begin
            @(negedge clk);
            if (Done) begin seen = 1'b1; break; end
            if (Busy) busy_cycles++;
        end
        check({name, "_done"}, int'(seen), 1);
        check({name, "_res"}, int'(ULAResult), exp_res);
        check({name, "_hi"}, int'(ULAResultHi), exp_hi);
        check({name, "_divzero"}, int'(DivZero), exp_dz);
        check({name, "_busy_cycles"}, busy_cycles, exp_busy);
    endtask

    initial begin
        int pulses;
        check("model_sra", int'(model_op(8, 'h90, 3).res), 'hF2);
        check("model_mul_hi", int'(model_op(9, 200, 3).hi), 'h02);

        repeat (3) @(posedge clk);
        check("reset_res", int'(ULAResult), 0);
        check("reset_busy_done", int'({Busy, Done}), 0);
        #1 reset = 1'b0;

        run_op("add_ff_01", 0, 'hFF, 'h01, 'h00, 0, 0, 0);
        check("add_flags_zcv", int'({Zero, Carry, Overflow}), 'b110);
        run_op("sub_80_01", 1, 'h80, 'h01, 'h7F, 0, 0, 0);
        check("sub_flags_ocn", int'({Overflow, Carry, Negative}), 'b110);
        run_op("slt_3_5", 5, 3, 5, 1, 0, 0, 0);
        run_op("sra_90_3", 8, 'h90, 3, 'hF2, 0, 0, 0);
        run_op("mul_200_3", 9, 200, 3, 'h58, 'h02, 0, WIDTH);
`ifdef ULA_DIV_EN
        run_op("divu_100_7", 10, 100, 7, 'h0E, 0, 0, WIDTH);
        run_op("remu_100_7", 11, 100, 7, 'h02, 0, 0, WIDTH);
        run_op("divu_5_0", 10, 5, 0, 'hFF, 0, 1, 0);
        run_op("add_clears_dz", 0, 1, 2, 3, 0, 0, 0);
`else
        run_op("divu_5_0_off", 10, 5, 0, 'h00, 0, 0, 0);
        run_op("divu_100_7_off", 10, 100, 7, 'h00, 0, 0, 0);
`endif
        run_op("reserved_c", 12, 5, 6, 0, 0, 0, 0);
        check("reserved_zero", int'(Zero), 1);

        // ADD issued in the third busy cycle of a MUL must be dropped.
        @(posedge clk); #1;
        Start = 1'b1; ULAControl = 4'd9; SrcA = 8'd200; SrcB = 8'd3;
        @(posedge clk); #1; Start = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        Start = 1'b1; ULAControl = 4'd0; SrcA = 8'd1; SrcB = 8'd1;
        @(posedge clk); #1; Start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3 * WIDTH; i++) begin
            @(negedge clk);
            if (Done) pulses++;
        end
        check("mul_ignore_pulses", pulses, 1);
        check("mul_ignore_res", int'(ULAResult), 'h58);
        check("mul_ignore_hi", int'(ULAResultHi), 'h02);

        // Asynchronous reset in the middle of a MUL.
        @(posedge clk); #1;
        Start = 1'b1; ULAControl = 4'd9; SrcA = 8'd200; SrcB = 8'd3;
        @(posedge clk); #1; Start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("rst_mid_res", int'({ULAResult, ULAResultHi}), 0);
        check("rst_mid_ctl", int'({Busy, Done, Zero, Negative, Carry, Overflow, DivZero}), 0);
        @(posedge clk); #1 reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            @(negedge clk);
            if (Done) pulses++;
        end
        check("rst_mid_no_done", pulses, 0);
        run_op("after_rst_add", 0, 2, 3, 5, 0, 0, 0);

        // Randomized traffic, checked every cycle by the model process.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            reset      = ($urandom_range(0, 199) == 0);
            Start      = ($urandom_range(0, 2) != 0);
            ULAControl = 4'($urandom_range(0, 15));
            SrcA       = WIDTH'($urandom);
            SrcB       = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
        end
        @(posedge clk); #1;
        reset = 1'b0; Start = 1'b0;
        repeat (2 * WIDTH) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
